// File: rtl/uart_instr_loader_pkg.sv
// Shared definitions for the UART instruction loader.
// Holds the FSM encodings, the frame layout constants and a word-assembly helper.
package uart_instr_loader_pkg;

    // Loader FSM states
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_WORD   = 3'd3,
        ST_WRITE  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_t;

    // UART receiver states
    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

    // Frame layout: 16-bit big-endian word count, then big-endian words
    localparam int HDR_BYTES  = 2;
    localparam int WORD_BYTES = 4;

    // Append one byte to a partially assembled word (MSB byte first)
    function automatic logic [31:0] shift_in_byte(
        input logic [31:0] word,
        input logic [7:0]  b
    );
        return {word[23:0], b};
    endfunction

endpackage

// File: rtl/uart_instr_loader_rx.sv
// 8N1 UART receiver: 2-FF synchroniser, start-edge detect, bit timer and deserialiser.
// Ports: clk, reset (sync, active-high), rxd (serial in), rx_valid/rx_data (byte pulse), rx_ferr (stop bit low).
module uart_rx
    import uart_instr_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rxd,
    output logic       rx_valid,
    output logic [7:0] rx_data,
    output logic       rx_ferr
);

    localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_M1  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    rx_state_t      state;
    logic           sync1;
    logic           sync2;
    logic           prev;
    logic [CW-1:0]  cnt;
    logic [2:0]     bit_idx;
    logic [7:0]     shift;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1    <= 1'b1;
            sync2    <= 1'b1;
            prev     <= 1'b1;
            state    <= RX_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            rx_valid <= 1'b0;
            rx_data  <= '0;
            rx_ferr  <= 1'b0;
        end else begin
            sync1    <= rxd;
            sync2    <= sync1;
            prev     <= sync2;
            rx_valid <= 1'b0;
            rx_ferr  <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    cnt <= '0;
                    // Only a high-to-low transition starts a frame, so a line
                    // left low after a bad stop bit does not retrigger.
                    if (prev && !sync2) begin
                        state <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt == HALF_M1) begin
                        cnt <= '0;
                        if (!sync2) begin
                            state   <= RX_DATA;
                            bit_idx <= '0;
                        end else begin
                            state <= RX_IDLE;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (cnt == BIT_M1) begin
                        cnt   <= '0;
                        shift <= {sync2, shift[7:1]};
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end else begin
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (cnt == BIT_M1) begin
                        cnt   <= '0;
                        state <= RX_IDLE;
                        if (sync2) begin
                            rx_valid <= 1'b1;
                            rx_data  <= shift;
                        end else begin
                            rx_ferr <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_instr_loader.sv
// Boot loader: receives a length-prefixed program over UART and writes it into instr_mem.
// Ports: clk, reset, uart_on, uart_rxd in; imem_we/imem_addr/imem_wdata, cpu_hold, load_done, load_err out.
module uart_instr_loader
    import uart_instr_loader_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int ADDR_W       = 8,
    parameter int TIMEOUT      = 2000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              uart_on,
    input  logic              uart_rxd,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              cpu_hold,
    output logic              load_done,
    output logic              load_err
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]   TMO_LAST  = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0]   TMO_ONE   = TW'(1);
    localparam logic [16:0]     MAX_WORDS = 17'(2 ** ADDR_W);
    localparam logic [ADDR_W:0] CNT_ONE   = (ADDR_W + 1)'(1);
    localparam logic [1:0]      LAST_BYTE = 2'(WORD_BYTES - 1);

    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ferr;

    loader_state_t   state;
    logic [15:0]     len;
    logic [ADDR_W:0] word_cnt;
    logic [1:0]      byte_idx;
    logic [31:0]     asm_word;
    logic [TW-1:0]   tmo_cnt;

    logic            rx_state;
    logic [15:0]     n_words;
    logic [ADDR_W:0] cnt_next;
    logic            last_word;
    logic            tmo_hit;
    logic            go_err;
    logic [31:0]     word_next;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clk      (clk),
        .reset    (reset),
        .rxd      (uart_rxd),
        .rx_valid (rx_valid),
        .rx_data  (rx_data),
        .rx_ferr  (rx_ferr)
    );

    always_comb begin
        rx_state  = (state == ST_LEN_HI) || (state == ST_LEN_LO)
                 || (state == ST_WORD);
        n_words   = {len[15:8], rx_data};
        cnt_next  = word_cnt + CNT_ONE;
        last_word = (16'(cnt_next) == len);
        tmo_hit   = (tmo_cnt == TMO_LAST);
        // A byte arriving in the expiry cycle wins over the timeout.
        go_err    = rx_state && (rx_ferr || (tmo_hit && !rx_valid));
        word_next = shift_in_byte(asm_word, rx_data);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            len        <= '0;
            word_cnt   <= '0;
            byte_idx   <= '0;
            asm_word   <= '0;
            tmo_cnt    <= '0;
            imem_we    <= 1'b0;
            imem_addr  <= '0;
            imem_wdata <= '0;
            cpu_hold   <= 1'b0;
            load_done  <= 1'b0;
            load_err   <= 1'b0;
        end else if (!uart_on) begin
            // Abort or stay transparent; addr/data keep their last value
            state     <= ST_IDLE;
            word_cnt  <= '0;
            byte_idx  <= '0;
            tmo_cnt   <= '0;
            imem_we   <= 1'b0;
            cpu_hold  <= 1'b0;
            load_done <= 1'b0;
            load_err  <= 1'b0;
        end else if (go_err) begin
            state    <= ST_ERR;
            tmo_cnt  <= '0;
            imem_we  <= 1'b0;
            cpu_hold <= 1'b1;
            load_err <= 1'b1;
        end else begin
            imem_we <= 1'b0;
            if (rx_state) begin
                tmo_cnt <= rx_valid ? '0 : tmo_cnt + TMO_ONE;
            end
            unique case (state)
                ST_IDLE: begin
                    state    <= ST_LEN_HI;
                    cpu_hold <= 1'b1;
                    tmo_cnt  <= '0;
                end
                ST_LEN_HI: begin
                    if (rx_valid) begin
                        len[15:8] <= rx_data;
                        state     <= ST_LEN_LO;
                    end
                end
                ST_LEN_LO: begin
                    if (rx_valid) begin
                        len[7:0] <= rx_data;
                        if (n_words == 16'd0) begin
                            state     <= ST_DONE;
                            cpu_hold  <= 1'b0;
                            load_done <= 1'b1;
                        end else if ({1'b0, n_words} > MAX_WORDS) begin
                            state    <= ST_ERR;
                            load_err <= 1'b1;
                        end else begin
                            state    <= ST_WORD;
                            byte_idx <= '0;
                            word_cnt <= '0;
                        end
                    end
                end
                ST_WORD: begin
                    if (rx_valid) begin
                        asm_word <= word_next;
                        byte_idx <= byte_idx + 2'd1;
                        if (byte_idx == LAST_BYTE) begin
                            // Strobe is registered, so it is high during WRITE
                            state      <= ST_WRITE;
                            imem_we    <= 1'b1;
                            imem_addr  <= word_cnt[ADDR_W-1:0];
                            imem_wdata <= word_next;
                        end
                    end
                end
                ST_WRITE: begin
                    word_cnt <= cnt_next;
                    byte_idx <= '0;
                    tmo_cnt  <= '0;
                    if (last_word) begin
                        state     <= ST_DONE;
                        cpu_hold  <= 1'b0;
                        load_done <= 1'b1;
                    end else begin
                        state <= ST_WORD;
                    end
                end
                ST_DONE: state <= ST_DONE;
                ST_ERR:  state <= ST_ERR;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_instr_loader.sv
// Self-checking bench for uart_instr_loader.
// Table of frame vectors plus directed sequences for framing error and reset mid-word.
module tb_uart_instr_loader;
    import uart_instr_loader_pkg::*;

    localparam int CPB    = 4;
    localparam int AW     = 4;
    localparam int TMO    = 200;

    logic          clk;
    logic          reset;
    logic          uart_on;
    logic          uart_rxd;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic          cpu_hold;
    logic          load_done;
    logic          load_err;

    uart_instr_loader #(
        .CLKS_PER_BIT(CPB),
        .ADDR_W      (AW),
        .TIMEOUT     (TMO)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .uart_on    (uart_on),
        .uart_rxd   (uart_rxd),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .cpu_hold   (cpu_hold),
        .load_done  (load_done),
        .load_err   (load_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        on;
        int          n;
        logic [95:0] bytes;
        logic        exp_done;
        logic        exp_err;
        logic        exp_hold;
        int          exp_writes;
        logic [31:0] w0;
        logic [31:0] w1;
    } vec_t;

    int n_checks = 0;
    int n_fail   = 0;

    // Write monitor, sampled on the falling edge
    logic          mon_clr;
    int            we_cnt;
    logic [AW-1:0] addr_log [0:3];
    logic [31:0]   data_log [0:3];
    logic          hold_seen;
    logic          we_hold;
    logic          post_pending;
    logic          post_hold;
    logic          post_done;

    always @(negedge clk) begin
        if (mon_clr) begin
            we_cnt       <= 0;
            hold_seen    <= 1'b0;
            we_hold      <= 1'b0;
            post_pending <= 1'b0;
            post_hold    <= 1'b1;
            post_done    <= 1'b0;
        end else begin
            if (cpu_hold) hold_seen <= 1'b1;
            post_pending <= imem_we;
            if (post_pending) begin
                post_hold <= cpu_hold;
                post_done <= load_done;
            end
            if (imem_we) begin
                if (we_cnt < 4) begin
                    addr_log[we_cnt[1:0]] <= imem_addr;
                    data_log[we_cnt[1:0]] <= imem_wdata;
                end
                we_cnt  <= we_cnt + 1;
                we_hold <= cpu_hold;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        uart_rxd = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rxd = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rxd = stop;
        repeat (CPB) @(negedge clk);
        uart_rxd = 1'b1;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic do_reset();
        uart_on  = 1'b0;
        uart_rxd = 1'b1;
        reset    = 1'b1;
        mon_clr  = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1 mon_clr = 1'b0;
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    vec_t vecs [0:6];

    initial begin
        vecs[0] = '{on: 1'b1, n: 10, bytes: 96'h000220080005081000000000,
                    exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0,
                    exp_writes: 2, w0: 32'h20080005, w1: 32'h08100000};
        vecs[1] = '{on: 1'b0, n: 6, bytes: 96'h000111223344000000000000,
                    exp_done: 1'b0, exp_err: 1'b0, exp_hold: 1'b0,
                    exp_writes: 0, w0: 32'h0, w1: 32'h0};
        vecs[2] = '{on: 1'b1, n: 2, bytes: 96'h001100000000000000000000,
                    exp_done: 1'b0, exp_err: 1'b1, exp_hold: 1'b1,
                    exp_writes: 0, w0: 32'h0, w1: 32'h0};
        vecs[3] = '{on: 1'b1, n: 2, bytes: 96'h000000000000000000000000,
                    exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0,
                    exp_writes: 0, w0: 32'h0, w1: 32'h0};
        vecs[4] = '{on: 1'b1, n: 6, bytes: 96'h0001AABBCCDD000000000000,
                    exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0,
                    exp_writes: 1, w0: 32'hAABBCCDD, w1: 32'h0};
        vecs[5] = '{on: 1'b1, n: 4, bytes: 96'h000120080000000000000000,
                    exp_done: 1'b0, exp_err: 1'b1, exp_hold: 1'b1,
                    exp_writes: 0, w0: 32'h0, w1: 32'h0};
        // N=16 is the largest legal count: first word lands, then timeout
        vecs[6] = '{on: 1'b1, n: 6, bytes: 96'h001001020304000000000000,
                    exp_done: 1'b0, exp_err: 1'b1, exp_hold: 1'b1,
                    exp_writes: 1, w0: 32'h01020304, w1: 32'h0};

        // Reset state
        uart_on  = 1'b1;
        uart_rxd = 1'b1;
        reset    = 1'b1;
        mon_clr  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst imem_we",    32'(imem_we),   32'h0);
        check("rst imem_addr",  32'(imem_addr), 32'h0);
        check("rst imem_wdata", imem_wdata,     32'h0);
        check("rst cpu_hold",   32'(cpu_hold),  32'h0);
        check("rst load_done",  32'(load_done), 32'h0);
        check("rst load_err",   32'(load_err),  32'h0);

        // Table-driven frames
        for (int v = 0; v < 7; v++) begin
            do_reset();
            uart_on = vecs[v].on;
            for (int i = 0; i < vecs[v].n; i++) begin
                send_byte(vecs[v].bytes[95 - 8 * i -: 8], 1'b1);
            end
            repeat (300) @(negedge clk);
            check($sformatf("v%0d load_done", v), 32'(load_done),
                  32'(vecs[v].exp_done));
            check($sformatf("v%0d load_err", v), 32'(load_err),
                  32'(vecs[v].exp_err));
            check($sformatf("v%0d cpu_hold", v), 32'(cpu_hold),
                  32'(vecs[v].exp_hold));
            check($sformatf("v%0d writes", v), 32'(we_cnt),
                  32'(vecs[v].exp_writes));
            check($sformatf("v%0d hold_seen", v), 32'(hold_seen),
                  32'(vecs[v].on));
            if (vecs[v].exp_writes >= 1) begin
                check($sformatf("v%0d addr0", v), 32'(addr_log[0]), 32'h0);
                check($sformatf("v%0d data0", v), data_log[0], vecs[v].w0);
                check($sformatf("v%0d hold at write", v), 32'(we_hold),
                      32'h1);
            end
            if (vecs[v].exp_writes >= 2) begin
                check($sformatf("v%0d addr1", v), 32'(addr_log[1]), 32'h1);
                check($sformatf("v%0d data1", v), data_log[1], vecs[v].w1);
            end
            if (vecs[v].exp_writes >= 1 && vecs[v].exp_done) begin
                check($sformatf("v%0d hold after last", v), 32'(post_hold),
                      32'h0);
                check($sformatf("v%0d done after last", v), 32'(post_done),
                      32'h1);
            end
        end

        // Framing error mid-word, abort via uart_on, then reload
        do_reset();
        uart_on = 1'b1;
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b0);
        repeat (20) @(negedge clk);
        check("ferr load_err", 32'(load_err), 32'h1);
        check("ferr cpu_hold", 32'(cpu_hold), 32'h1);
        check("ferr writes",   32'(we_cnt),   32'h0);
        uart_on = 1'b0;
        @(negedge clk);
        check("abort load_err",  32'(load_err),  32'h0);
        check("abort load_done", 32'(load_done), 32'h0);
        check("abort cpu_hold",  32'(cpu_hold),  32'h0);
        repeat (5) @(negedge clk);
        clr_mon();
        uart_on = 1'b1;
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        send_byte(8'hCC, 1'b1);
        send_byte(8'hDD, 1'b1);
        repeat (50) @(negedge clk);
        check("reload load_done", 32'(load_done),   32'h1);
        check("reload cpu_hold",  32'(cpu_hold),    32'h0);
        check("reload writes",    32'(we_cnt),      32'h1);
        check("reload addr0",     32'(addr_log[0]), 32'h0);
        check("reload data0",     data_log[0],      32'hAABBCCDD);

        // Reset asserted while the 4th byte of a word is on the wire
        do_reset();
        uart_on = 1'b1;
        send_byte(8'h00, 1'b1);
        send_byte(8'h01, 1'b1);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h33, 1'b1);
        check("pre-rst cpu_hold", 32'(cpu_hold), 32'h1);
        uart_rxd = 1'b0;
        repeat (CPB * 3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst imem_we",   32'(imem_we),   32'h0);
        check("midrst cpu_hold",  32'(cpu_hold),  32'h0);
        check("midrst load_done", 32'(load_done), 32'h0);
        check("midrst load_err",  32'(load_err),  32'h0);
        check("midrst imem_addr", 32'(imem_addr), 32'h0);
        uart_rxd = 1'b1;
        repeat (60) @(negedge clk);
        reset = 1'b0;
        repeat (100) @(negedge clk);
        check("midrst writes", 32'(we_cnt), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
